// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator fed by two cascaded line buffers; emits one window per interior pixel.
// Optional build macro WINDOW_STRIDE2_EN: emit only windows whose top-left corner is on even col/row.
module window_gen_3x3 #(
    parameter int IMAGE_WIDTH  = 220,
    parameter int IMAGE_HEIGHT = 220,
    parameter int DIN_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    input  logic [DIN_WIDTH-1:0]   row0_in,
    input  logic [DIN_WIDTH-1:0]   row1_in,
    input  logic [DIN_WIDTH-1:0]   row2_in,
    output logic [9*DIN_WIDTH-1:0] win_out,
    output logic                   valid_out,
    output logic                   frame_done
);

    localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
`ifdef WINDOW_STRIDE2_EN
    // Last emitted window sits on the final even-offset column/row, not necessarily the last pixel.
    localparam logic [COL_W-1:0] EMIT_COL_LAST = COL_W'(IMAGE_WIDTH - 1 - ((IMAGE_WIDTH - 3) % 2));
    localparam logic [ROW_W-1:0] EMIT_ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1 - ((IMAGE_HEIGHT - 3) % 2));
`else
    localparam logic [COL_W-1:0] EMIT_COL_LAST = COL_LAST;
    localparam logic [ROW_W-1:0] EMIT_ROW_LAST = ROW_LAST;
`endif

    logic [DIN_WIDTH-1:0]   tap_q [3][3];
    logic [DIN_WIDTH-1:0]   tap_d [3][3];
    logic [DIN_WIDTH-1:0]   new_col [3];
    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [9*DIN_WIDTH-1:0] win_q, win_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   win_hit;
    logic                   last_hit;

    always_comb begin
        win_hit = (col_q >= COL_W'(2)) && (row_q >= ROW_W'(2));
`ifdef WINDOW_STRIDE2_EN
        win_hit = win_hit && !col_q[0] && !row_q[0];
`endif
        last_hit = win_hit && (col_q == EMIT_COL_LAST) && (row_q == EMIT_ROW_LAST);
    end

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        tap_d   = tap_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        new_col[0] = row2_in;
        new_col[1] = row1_in;
        new_col[2] = row0_in;
        if (valid_in) begin
            for (int r = 0; r < 3; r++) begin
                tap_d[r][0] = tap_q[r][1];
                tap_d[r][1] = tap_q[r][2];
                tap_d[r][2] = new_col[r];
            end
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (win_hit) begin
                valid_d = 1'b1;
                done_d  = last_hit;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        win_d[(r*3+c)*DIN_WIDTH +: DIN_WIDTH] = tap_d[r][c];
                    end
                end
            end
        end
    end

    // NOTE: the tap array is only nine words, so it is reset along with the rest of the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    tap_q[r][c] <= '0;
                end
            end
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of order.
            tap_q   <= tap_d;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign win_out    = win_q;
    assign valid_out  = valid_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3: random images and gaps checked against an image-indexed window model.
module tb_window_gen_3x3;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int DW = 8;
    localparam int WB = 9 * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] row0_in, row1_in, row2_in;
    logic [WB-1:0] win_out;
    logic          valid_out;
    logic          frame_done;

    window_gen_3x3 #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DIN_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .row0_in    (row0_in),
        .row1_in    (row1_in),
        .row2_in    (row2_in),
        .win_out    (win_out),
        .valid_out  (valid_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] img [H][W];
    int            beat_idx;
    int            win_count;
    int            done_count;
    logic [WB-1:0] last_win;
    logic [WB-1:0] first_win;
    logic [WB-1:0] ref_first;

    task automatic check(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit qualifies(int r, int c);
        bit q = (r >= 2) && (c >= 2);
`ifdef WINDOW_STRIDE2_EN
        q = q && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
`endif
        return q;
    endfunction

    // Last qualifying position in raster order, found by scanning the whole frame.
    function automatic bit is_last(int r, int c);
        int lr = -1, lc = -1;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (qualifies(y, x)) begin lr = y; lc = x; end
        return (r == lr) && (c == lc);
    endfunction

    function automatic int windows_per_frame();
        int n = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (qualifies(y, x)) n++;
        return n;
    endfunction

    task automatic load_p_image();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = DW'(y * W + x);
    endtask

    task automatic load_rand_image();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = DW'($urandom);
    endtask

    task automatic start_frame_stats();
        win_count  = 0;
        done_count = 0;
        first_win  = '0;
    endtask

    task automatic end_frame_stats(input string tag);
        check({tag, "_win_count"}, WB'(win_count), WB'(windows_per_frame()));
        check({tag, "_done_count"}, WB'(done_count), WB'(1));
    endtask

    // One clock: present a beat (or a gap), then check the registered response 1 time unit after the edge.
    task automatic step(input bit v);
        int r, c;
        logic [WB-1:0] exp_w;
        bit exp_v;
        r = beat_idx / W;
        c = beat_idx % W;
        valid_in = v;
        row0_in  = v ? img[r][c] : DW'($urandom);
        row1_in  = (v && r >= 1) ? img[r-1][c] : DW'($urandom);
        row2_in  = (v && r >= 2) ? img[r-2][c] : DW'($urandom);
        @(posedge clk);
        #1;
        exp_v = v && qualifies(r, c);
        check("valid_out", WB'(valid_out), WB'(exp_v));
        if (exp_v) begin
            exp_w = '0;
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++)
                    exp_w[(rr*3+cc)*DW +: DW] = img[r-2+rr][c-2+cc];
            check("win_out", win_out, exp_w);
            check("frame_done", WB'(frame_done), WB'(is_last(r, c)));
            if (win_count == 0) first_win = win_out;
            win_count++;
            if (frame_done) done_count++;
            last_win = exp_w;
        end else begin
            check("win_hold", win_out, last_win);
            check("frame_done_idle", WB'(frame_done), WB'(0));
        end
        if (v) beat_idx = (beat_idx + 1) % (W * H);
    endtask

    task automatic send_frame(input int gap_mode);
        for (int i = 0; i < W * H; i++) begin
            step(1'b1);
            if (gap_mode == 1) begin
                for (int g = 0; g < 3; g++) step(1'b0);
            end else if (gap_mode == 2) begin
                int ng = $urandom_range(0, 3);
                for (int g = 0; g < ng; g++) step(1'b0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_win"}, win_out, '0);
        check({tag, "_valid"}, WB'(valid_out), WB'(0));
        check({tag, "_done"}, WB'(frame_done), WB'(0));
    endtask

    initial begin
        // First window of the p=row*5+col frame: slots k=0..8 hold 0,1,2,5,6,7,10,11,12.
        ref_first = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
        reset    = 1'b0;
        valid_in = 1'b0;
        row0_in  = '0;
        row1_in  = '0;
        row2_in  = '0;
        beat_idx = 0;
        last_win = '0;
        load_p_image();
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'($urandom);
            row0_in  = DW'($urandom);
            @(posedge clk);
            #1;
            check_reset_outputs("reset_init");
        end
        valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Continuous p-valued frame.
        start_frame_stats();
        send_frame(0);
        end_frame_stats("cont");
        check("cont_first_win", first_win, ref_first);

        // Same frame with three idle cycles after every beat.
        start_frame_stats();
        send_frame(1);
        end_frame_stats("gap3");
        check("gap3_first_win", first_win, ref_first);

        // Two random frames back-to-back, no idle between them.
        for (int f = 0; f < 2; f++) begin
            load_rand_image();
            start_frame_stats();
            send_frame(0);
            end_frame_stats("b2b");
        end

        // Random frames with random gaps.
        for (int f = 0; f < 3; f++) begin
            load_rand_image();
            start_frame_stats();
            send_frame(2);
            end_frame_stats("rgap");
        end

        // Mid-frame reset after beat p=13, then a fresh frame.
        load_p_image();
        start_frame_stats();
        for (int i = 0; i < 14; i++) step(1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            row0_in  = DW'($urandom);
            @(posedge clk);
            #1;
            check_reset_outputs("reset_hold");
        end
        valid_in = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        beat_idx = 0;
        last_win = '0;
        start_frame_stats();
        send_frame(0);
        end_frame_stats("post_reset");
        check("post_reset_first_win", first_win, ref_first);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
